// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Word-addressed data memory with a fixed request-to-response
//                latency, alignment/range error reporting and a ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        WrEn,
    input  logic [31:0] adr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          c_ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_LIMIT  = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_LAT    = 4'(LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic [31:0]         r_adr;
    logic [31:0]         r_data;
    logic                r_err;
    logic [31:0]         r_dout;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_op_wr;
    logic [31:0]         w_op_adr;
    logic [31:0]         w_op_data;
    logic                w_op_err;
    logic [c_ADDR_W-1:0] w_idx;

    // The operation completing this edge comes from the capture registers when
    // leaving WAIT, or straight from the inputs when LATENCY is zero.
    always_comb begin
        w_accept     = req && (r_state != ST_WAIT);
        w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == 4'd1)) ||
                       (w_accept && (c_LAT == 4'd0));
        w_op_wr      = (r_state == ST_WAIT) ? r_wr   : WrEn;
        w_op_adr     = (r_state == ST_WAIT) ? r_adr  : adr;
        w_op_data    = (r_state == ST_WAIT) ? r_data : DataIn;
        w_op_err     = (w_op_adr[1:0] != 2'b00) || (w_op_adr >= c_LIMIT);
        w_idx        = w_op_adr[c_ADDR_W+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_dout  <= 32'h0000_0000;
        end else begin
            r_err <= w_enter_resp && w_op_err;
            if (w_enter_resp) begin
                r_state <= ST_RESP;
                r_cnt   <= 4'd0;
                if (!w_op_wr) begin
                    r_dout <= w_op_err ? 32'h0000_0000 : r_mem[w_idx];
                end
            end else if (w_accept) begin
                r_state <= ST_WAIT;
                r_cnt   <= c_LAT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_wr   <= WrEn;
            r_adr  <= adr;
            r_data <= DataIn;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_op_wr && !w_op_err) begin
            r_mem[w_idx] <= w_op_data;
        end
    end

    assign DataOut = r_dout;
    assign ready   = (r_state == ST_RESP);
    assign err     = r_err;
    assign busy    = (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Bench for dmem_responder at LATENCY=2 and LATENCY=0 against
//                a transaction/timestamp model plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_LAT [2] = '{2, 0};

    logic        clk;
    logic        rst;
    logic        req  [2];
    logic        wr   [2];
    logic [31:0] adr  [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        err  [2];
    logic        busy [2];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .WrEn(wr[0]), .adr(adr[0]),
        .DataIn(din[0]), .DataOut(dout[0]), .ready(rdy[0]), .err(err[0]),
        .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .WrEn(wr[1]), .adr(adr[1]),
        .DataIn(din[1]), .DataOut(dout[1]), .ready(rdy[1]), .err(err[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each request gets a due edge (accept edge + LATENCY); at that edge
    // the access is applied to a reference memory and the response is produced.
    bit [31:0]   m_mem   [2][256];
    bit          m_known [2][256];
    bit          m_wait  [2];
    int          m_due   [2];
    bit          m_t_wr  [2];
    logic [31:0] m_t_adr [2];
    logic [31:0] m_t_dat [2];
    logic        m_rdy   [2];
    logic        m_err   [2];
    logic        m_busy  [2];
    logic [31:0] m_dout  [2];
    bit          m_dk    [2];
    int          ecnt = 0;
    bit          chk_en = 0;

    task automatic model_step(input int d);
        bit done;
        bit e;
        int idx;
        if (rst) begin
            m_wait[d] = 0;
            m_rdy[d]  = 0;
            m_err[d]  = 0;
            m_busy[d] = 0;
            m_dout[d] = 32'h0;
            m_dk[d]   = 1;
        end else begin
            done     = 0;
            m_rdy[d] = 0;
            m_err[d] = 0;
            if (m_wait[d]) begin
                if (ecnt == m_due[d]) begin
                    done      = 1;
                    m_wait[d] = 0;
                end
            end else if (req[d] === 1'b1) begin
                m_t_wr[d]  = wr[d];
                m_t_adr[d] = adr[d];
                m_t_dat[d] = din[d];
                m_due[d]   = ecnt + c_LAT[d];
                if (c_LAT[d] == 0) done = 1;
                else m_wait[d] = 1;
            end
            if (done) begin
                e   = (m_t_adr[d] % 4 != 0) || (m_t_adr[d] >= 1024);
                idx = int'(m_t_adr[d] / 4) % 256;
                m_rdy[d] = 1;
                m_err[d] = e;
                if (m_t_wr[d]) begin
                    if (!e) begin
                        m_mem[d][idx]   = m_t_dat[d];
                        m_known[d][idx] = 1;
                    end
                end else if (e) begin
                    m_dout[d] = 32'h0;
                    m_dk[d]   = 1;
                end else begin
                    m_dout[d] = m_mem[d][idx];
                    m_dk[d]   = m_known[d][idx];
                end
            end
            m_busy[d] = m_wait[d];
        end
    endtask

    always @(posedge clk) begin
        ecnt++;
        if (rst) chk_en = 1;
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready%0d", d), 32'(rdy[d]),  32'(m_rdy[d]));
                chk($sformatf("busy%0d", d),  32'(busy[d]), 32'(m_busy[d]));
                chk($sformatf("err%0d", d),   32'(err[d]),  32'(m_err[d]));
                if (m_dk[d]) chk($sformatf("dout%0d", d), dout[d], m_dout[d]);
            end
        end
    end

    // Called at a negedge; returns at the negedge on which ready is seen.
    task automatic issue(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] dt, input bit noise, output int lat);
        req[d] = 1'b1;
        wr[d]  = w;
        adr[d] = a;
        din[d] = dt;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req[d] = (noise && k == 1);
            if (noise && k == 1) begin
                wr[d]  = 1'b1;
                adr[d] = a;
                din[d] = 32'h0BAD_0BAD;
            end
            if (rdy[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
        req[d] = 1'b0;
        chk($sformatf("latency%0d", d), 32'(lat), 32'(c_LAT[d] + 1));
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; adr[d] = 32'h0; din[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", dout[0], 32'h0);
        chk("reset_ready", 32'(rdy[0]), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 1, 32'h30, 32'h1111_2222, 0, lat);
        @(negedge clk);
        issue(0, 1, 32'h10, 32'hDEAD_BEEF, 0, lat);
        chk("wr10_err", 32'(err[0]), 32'h0);
        @(negedge clk);
        issue(0, 0, 32'h10, 32'h0, 0, lat);
        chk("rd10_data", dout[0], 32'hDEAD_BEEF);
        @(negedge clk);
        issue(0, 1, 32'h13, 32'h1, 0, lat);
        chk("misaligned_err", 32'(err[0]), 32'h1);
        @(negedge clk);
        issue(0, 0, 32'h10, 32'h0, 0, lat);
        chk("rd10_after_bad", dout[0], 32'hDEAD_BEEF);
        @(negedge clk);
        issue(0, 0, 32'h400, 32'h0, 0, lat);
        chk("oor_err", 32'(err[0]), 32'h1);
        chk("oor_data", dout[0], 32'h0);
        @(negedge clk);

        issue(0, 1, 32'h20, 32'h1234_5678, 1, lat);
        issue(0, 0, 32'h20, 32'h0, 0, lat);
        chk("b2b_data", dout[0], 32'h1234_5678);
        @(negedge clk);

        // Abort an in-flight write with reset; also present a request in the reset cycle.
        req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h30; din[0] = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", 32'(rdy[0]), 32'h0);
        chk("abort_busy", 32'(busy[0]), 32'h0);
        chk("abort_dout", dout[0], 32'h0);
        rst = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        issue(0, 0, 32'h30, 32'h0, 0, lat);
        chk("rd30_after_abort", dout[0], 32'h1111_2222);
        @(negedge clk);

        issue(0, 1, 32'h3FC, 32'h5A5A_A5A5, 0, lat);
        issue(0, 1, 32'h3FE, 32'hFFFF_FFFF, 0, lat);
        issue(0, 0, 32'h3FC, 32'h0, 0, lat);
        chk("last_word", dout[0], 32'h5A5A_A5A5);
        @(negedge clk);

        issue(1, 1, 32'h8, 32'hCAFE_F00D, 0, lat);
        issue(1, 0, 32'h8, 32'h0, 0, lat);
        chk("l0_b2b_data", dout[1], 32'hCAFE_F00D);
        issue(1, 0, 32'h404, 32'h0, 0, lat);
        chk("l0_oor_err", 32'(err[1]), 32'h1);
        @(negedge clk);
        chk("l0_idle_ready", 32'(rdy[1]), 32'h0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
